// File: rtl/reg_bank_pkg.sv
// Shared types for the register bank transfer engine: command op codes,
// FSM states and the register-select range helper.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_SWAP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_SW_A = 3'd2,
        ST_SW_B = 3'd3,
        ST_SW_C = 3'd4
    } state_e;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_regs);
        return sel < num_regs;
    endfunction

endpackage

// File: rtl/reg_bank_xfer_if.sv
// Command/completion handshake between the control unit (master) and the
// register bank transfer engine (slave).
interface reg_bank_xfer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [SEL_W-1:0]  req_src;
    logic [SEL_W-1:0]  req_dst;
    logic [DATA_W-1:0] req_data;
    logic              done;
    logic              err;
    logic              busy;

    modport master (
        output req_valid, req_op, req_src, req_dst, req_data,
        input  req_ready, done, err, busy
    );

    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_data,
        output req_ready, done, err, busy
    );
endinterface

// File: rtl/reg_array.sv
// NUM_REGS x DATA_W register storage: one write port, two external read ports
// and one engine read port, all masked for out-of-range and zero-register selects.
module reg_array
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS),
    parameter bit          R0_ZERO  = 1'b1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SEL_W-1:0]  rd_sel_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [SEL_W-1:0]  rd_sel_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [SEL_W-1:0]  eng_sel,
    output logic [DATA_W-1:0] eng_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // A select is usable when it names a real register that is not the hard zero.
    function automatic logic usable(input logic [SEL_W-1:0] sel);
        return sel_in_range(32'(sel), NUM_REGS) && !(R0_ZERO && (sel == '0));
    endfunction

    // NOTE: the storage is reset explicitly because the bank must read all-zero
    // straight out of reset; a bank allowed to power up undefined would skip this loop.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && usable(wr_sel)) begin
            regs[wr_sel] <= wr_data;
        end
    end

    assign rd_data_a = usable(rd_sel_a) ? regs[rd_sel_a] : '0;
    assign rd_data_b = usable(rd_sel_b) ? regs[rd_sel_b] : '0;
    assign eng_data  = usable(eng_sel)  ? regs[eng_sel]  : '0;

endmodule

// File: rtl/reg_bank_xfer.sv
// Register bank with a handshaked transfer engine executing MOVE, LOAD,
// CLEAR (one execute cycle) and SWAP (three cycles through a temporary).
module reg_bank_xfer
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS),
    parameter bit          R0_ZERO  = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clock,
    input  logic              clear,
    reg_bank_xfer_if.slave    bus,
    input  logic [SEL_W-1:0]  rd_sel_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [SEL_W-1:0]  rd_sel_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [CNT_W-1:0]  op_count
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [SEL_W-1:0]  src_q, dst_q;
    logic [DATA_W-1:0] data_q, tmp_q;
    logic              done_q, err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              finish;
    logic              bad_sel;
    logic              wr_en;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [SEL_W-1:0]  eng_sel;
    logic [DATA_W-1:0] eng_data;

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    // dst is always checked; src only matters for the ops that read it.
    assign bad_sel = !sel_in_range(32'(dst_q), NUM_REGS) ||
                     (((op_q == OP_MOVE) || (op_q == OP_SWAP)) &&
                      !sel_in_range(32'(src_q), NUM_REGS));

    // NOTE: every output of this block gets a default before the case so that no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_sel  = dst_q;
        wr_data = '0;
        eng_sel = src_q;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (op_e'(bus.req_op) == OP_SWAP) ? ST_SW_A : ST_EXEC;
                end
            end
            ST_EXEC: begin
                wr_en = 1'b1;
                case (op_q)
                    OP_MOVE: wr_data = eng_data;
                    OP_LOAD: wr_data = data_q;
                    default: wr_data = '0;
                endcase
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_SW_A: begin
                state_d = ST_SW_B;
            end
            ST_SW_B: begin
                wr_en   = 1'b1;
                wr_sel  = src_q;
                eng_sel = dst_q;
                wr_data = eng_data;
                state_d = ST_SW_C;
            end
            ST_SW_C: begin
                wr_en   = 1'b1;
                wr_sel  = dst_q;
                wr_data = tmp_q;
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q   <= OP_MOVE;
            src_q  <= '0;
            dst_q  <= '0;
            data_q <= '0;
            tmp_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_e'(bus.req_op);
                src_q  <= bus.req_src;
                dst_q  <= bus.req_dst;
                data_q <= bus.req_data;
            end
            if (state_q == ST_SW_A) begin
                tmp_q <= eng_data;
            end
            done_q <= finish;
            err_q  <= finish && bad_sel;
            if (finish) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    reg_array #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W),
        .R0_ZERO  (R0_ZERO)
    ) u_reg_array (
        .clock     (clock),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_sel_a  (rd_sel_a),
        .rd_data_a (rd_data_a),
        .rd_sel_b  (rd_sel_b),
        .rd_data_b (rd_data_b),
        .eng_sel   (eng_sel),
        .eng_data  (eng_data)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign op_count      = cnt_q;

endmodule

// File: tb/tb_reg_bank_xfer.sv
// Directed bench for reg_bank_xfer with NUM_REGS=12, R0_ZERO=1, CNT_W=4 so that
// out-of-range selects and counter wrap are reachable.
module tb_reg_bank_xfer;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 12;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned CNT_W    = 4;

    logic              clock;
    logic              clear;
    logic [SEL_W-1:0]  rd_sel_a, rd_sel_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;
    logic [CNT_W-1:0]  op_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    reg_bank_xfer_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    reg_bank_xfer #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W),
        .R0_ZERO  (1'b1),
        .CNT_W    (CNT_W)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .bus       (bus),
        .rd_sel_a  (rd_sel_a),
        .rd_data_a (rd_data_a),
        .rd_sel_b  (rd_sel_b),
        .rd_data_b (rd_data_b),
        .op_count  (op_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                         input logic [31:0] data);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src   = src;
        bus.req_dst   = dst;
        bus.req_data  = data;
    endtask

    // Issue one command and return in its done cycle (or after a bounded wait).
    task automatic issue(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                         input logic [31:0] data, output logic err_seen, output int cycles);
        drive(op, src, dst, data);
        tick();
        bus.req_valid = 1'b0;
        bus.req_data  = 32'hFFFF_FFFF;
        bus.req_dst   = 4'd1;
        cycles = 0;
        while (!bus.done && cycles < 10) begin
            tick();
            cycles++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        err_seen = bus.err;
    endtask

    logic e;
    int   cyc;

    initial begin
        clear         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        bus.req_data  = '0;
        rd_sel_a      = 4'd5;
        rd_sel_b      = 4'd9;
        tick();
        tick();
        clear = 1'b1;
        tick();

        check("rst_rd_a", rd_data_a, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);

        // LOAD r5 with the inputs changing right after acceptance
        drive(2'b01, 4'd0, 4'd5, 32'hDEAD_BEEF);
        tick();
        bus.req_valid = 1'b0;
        bus.req_data  = 32'h1234_5678;
        bus.req_dst   = 4'd6;
        check("load_busy", 32'(bus.busy), 32'd1);
        check("load_ready", 32'(bus.req_ready), 32'd0);
        check("load_done_early", 32'(bus.done), 32'd0);
        tick();
        check("load_done", 32'(bus.done), 32'd1);
        check("load_err", 32'(bus.err), 32'd0);
        check("load_r5", rd_data_a, 32'hDEAD_BEEF);
        check("load_count", 32'(op_count), 32'd1);
        check("load_ready_done", 32'(bus.req_ready), 32'd1);

        // MOVE r5->r9 issued in the LOAD's done cycle
        drive(2'b00, 4'd5, 4'd9, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        check("move_done_low", 32'(bus.done), 32'd0);
        check("move_busy", 32'(bus.busy), 32'd1);
        check("move_r9_before", rd_data_b, 32'h0);
        tick();
        check("move_done", 32'(bus.done), 32'd1);
        check("move_r9", rd_data_b, 32'hDEAD_BEEF);
        check("move_r5", rd_data_a, 32'hDEAD_BEEF);
        check("move_count", 32'(op_count), 32'd2);

        // SWAP r3 <-> r7
        issue(2'b01, 4'd0, 4'd3, 32'h11, e, cyc);
        issue(2'b01, 4'd0, 4'd7, 32'h22, e, cyc);
        rd_sel_a = 4'd3;
        rd_sel_b = 4'd7;
        drive(2'b10, 4'd3, 4'd7, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        check("swap_ready_1", 32'(bus.req_ready), 32'd0);
        tick();
        check("swap_ready_2", 32'(bus.req_ready), 32'd0);
        check("swap_done_2", 32'(bus.done), 32'd0);
        tick();
        check("swap_ready_3", 32'(bus.req_ready), 32'd0);
        check("swap_mid_r3", rd_data_a, 32'h22);
        check("swap_mid_r7", rd_data_b, 32'h22);
        tick();
        check("swap_done", 32'(bus.done), 32'd1);
        check("swap_r3", rd_data_a, 32'h22);
        check("swap_r7", rd_data_b, 32'h11);
        check("swap_count", 32'(op_count), 32'd5);
        tick();
        check("swap_done_once", 32'(bus.done), 32'd0);

        // Zero register and out-of-range destinations
        rd_sel_a = 4'd0;
        issue(2'b01, 4'd0, 4'd0, 32'h0000_FFFF, e, cyc);
        check("r0_err", 32'(e), 32'd0);
        tick();
        check("r0_read", rd_data_a, 32'h0);
        check("r0_count", 32'(op_count), 32'd6);

        rd_sel_a = 4'd13;
        issue(2'b01, 4'd0, 4'd13, 32'hCAFE_F00D, e, cyc);
        check("r13_err", 32'(e), 32'd1);
        check("r13_read", rd_data_a, 32'h0);
        check("r13_r3", 32'(dut.u_reg_array.regs[3]), 32'h22);
        tick();
        check("r13_done_low", 32'(bus.done), 32'd0);
        check("r13_err_low", 32'(bus.err), 32'd0);
        check("r13_count", 32'(op_count), 32'd7);

        rd_sel_a = 4'd11;
        issue(2'b01, 4'd0, 4'd11, 32'h0000_ABCD, e, cyc);
        check("r11_err", 32'(e), 32'd0);
        check("r11_read", rd_data_a, 32'h0000_ABCD);

        // MOVE from an invalid source writes zero and flags err
        rd_sel_b = 4'd9;
        issue(2'b00, 4'd14, 4'd9, 32'h0, e, cyc);
        check("badsrc_err", 32'(e), 32'd1);
        check("badsrc_r9", rd_data_b, 32'h0);
        check("badsrc_count", 32'(op_count), 32'd9);

        // SWAP with src == dst
        rd_sel_b = 4'd7;
        issue(2'b10, 4'd7, 4'd7, 32'h0, e, cyc);
        check("self_swap_cycles", 32'(cyc), 32'd3);
        check("self_swap_r7", rd_data_b, 32'h11);
        check("self_swap_err", 32'(e), 32'd0);

        // CLEAR r11
        issue(2'b11, 4'd0, 4'd11, 32'h0, e, cyc);
        check("clear_r11", rd_data_a, 32'h0);
        check("clear_count", 32'(op_count), 32'd11);

        // Reset asserted in the middle of a SWAP (after SW_A)
        rd_sel_a = 4'd3;
        rd_sel_b = 4'd7;
        drive(2'b10, 4'd3, 4'd7, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        clear = 1'b0;
        #1;
        check("mid_rst_r3", rd_data_a, 32'h0);
        check("mid_rst_r7", rd_data_b, 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        tick();
        clear = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_r3", rd_data_a, 32'h0);
        check("post_rst_r7", rd_data_b, 32'h0);
        check("post_rst_done", 32'(bus.done), 32'd0);
        check("post_rst_count", 32'(op_count), 32'd0);

        // Counter wrap: 17 CLEARs with CNT_W=4
        for (int i = 0; i < 17; i++) begin
            issue(2'b11, 4'd0, 4'd2, 32'h0, e, cyc);
            if (i == 15) begin
                check("wrap_16", 32'(op_count), 32'd0);
            end
        end
        check("wrap_17", 32'(op_count), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
